// File: rtl/smbus_reg_pkg.sv
// Shared definitions for the SMBus register bank.
// Holds the register address map, the counter-clear key, the unmapped read
// value and a byte-lane merge helper used by the 16-bit RW registers.
package smbus_reg_pkg;

  localparam logic [7:0] ADR_VERSION   = 8'h00;
  localparam logic [7:0] ADR_BOARD_ID  = 8'h01;
  localparam logic [7:0] ADR_STATUS_LO = 8'h02;
  localparam logic [7:0] ADR_STATUS_HI = 8'h03;
  localparam logic [7:0] ADR_FAULT_LO  = 8'h04;
  localparam logic [7:0] ADR_FAULT_HI  = 8'h05;
  localparam logic [7:0] ADR_MASK_LO   = 8'h06;
  localparam logic [7:0] ADR_MASK_HI   = 8'h07;
  localparam logic [7:0] ADR_CTRL_LO   = 8'h08;
  localparam logic [7:0] ADR_CTRL_HI   = 8'h09;
  localparam logic [7:0] ADR_SCRATCH   = 8'h0A;
  localparam logic [7:0] ADR_EVT_L     = 8'h0C;
  localparam logic [7:0] ADR_EVT_H     = 8'h0D;
  localparam logic [7:0] ADR_EVT_CLR   = 8'h0E;

  localparam logic [7:0]  EVT_CLR_KEY = 8'hA5;
  localparam logic [7:0]  RD_UNMAPPED = 8'hFF;
  localparam logic [15:0] EVT_MAX     = 16'hFFFF;

  // Replace one byte lane of a 16-bit register.
  function automatic logic [15:0] write_byte(input logic [15:0] cur,
                                             input logic        hi,
                                             input logic [7:0]  data);
    return hi ? {data, cur[7:0]} : {cur[15:8], data};
  endfunction

endpackage

// File: rtl/smbus_status_sync.sv
// Multi-bit synchronizer with rising-edge detect for the asynchronous fault
// inputs. Each bit passes through STAGES flops, then one extra delay flop so
// that a rising edge can be detected on the synchronized value.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   status in   WIDTH asynchronous inputs
//   sync   out  WIDTH synchronized inputs
//   rise   out  WIDTH one-clock pulses on a 0->1 of sync
module smbus_status_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] status,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      dly   <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], status};
      dly   <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~dly;

endmodule

// File: rtl/smbus_register_bank.sv
// Register file behind the SMBus slave engine.
// Provides board ID/version, synchronized live status, latched (W1C) faults,
// fault mask, control and scratch registers and a saturating 16-bit fault
// event counter with a high-byte shadow for coherent two-byte reads.
// Ports:
//   CLK_IN     in   clock
//   RESET_N    in   asynchronous active-low reset
//   I2C_CMD_I  in   register offset from the slave engine
//   I2C_DAT_I  in   write data
//   I2C_WREN   in   one-clock write strobe
//   I2C_RDEN   in   one-clock read-acknowledge strobe
//   RD_DAT_O   out  combinational read data for I2C_CMD_I
//   STATUS_I   in   asynchronous fault inputs, active high
//   CTRL_O     out  control register
//   ALERT_N    out  registered SMBus alert, active low
module smbus_register_bank
  import smbus_reg_pkg::*;
#(
  parameter logic [7:0] FW_VERSION  = 8'h01,
  parameter logic [7:0] BOARD_ID    = 8'h6E,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK_IN,
  input  logic        RESET_N,
  input  logic [7:0]  I2C_CMD_I,
  input  logic [7:0]  I2C_DAT_I,
  input  logic        I2C_WREN,
  input  logic        I2C_RDEN,
  output logic [7:0]  RD_DAT_O,
  input  logic [15:0] STATUS_I,
  output logic [15:0] CTRL_O,
  output logic        ALERT_N
);

  logic [15:0] status_sync;
  logic [15:0] status_rise;
  logic [15:0] fault_lat;
  logic [15:0] fault_mask;
  logic [15:0] ctrl;
  logic [7:0]  scratch;
  logic [15:0] evt_cnt;
  logic [7:0]  evt_shadow;
  logic        alert_n_q;

  logic [15:0] fault_clr;
  logic        evt_inc;
  logic        evt_clr;
  logic        snap;

  smbus_status_sync #(
    .WIDTH  (16),
    .STAGES (SYNC_STAGES)
  ) u_status_sync (
    .clk    (CLK_IN),
    .rst_n  (RESET_N),
    .status (STATUS_I),
    .sync   (status_sync),
    .rise   (status_rise)
  );

  // Write-side decode
  always_comb begin
    fault_clr = '0;
    if (I2C_WREN && I2C_CMD_I == ADR_FAULT_LO) fault_clr[7:0]  = I2C_DAT_I;
    if (I2C_WREN && I2C_CMD_I == ADR_FAULT_HI) fault_clr[15:8] = I2C_DAT_I;
  end

  assign evt_inc = |(status_rise & ~fault_mask);
  assign evt_clr = I2C_WREN && (I2C_CMD_I == ADR_EVT_CLR) && (I2C_DAT_I == EVT_CLR_KEY);
  // A simultaneous write takes priority, so RDEN is ignored when WREN is high.
  assign snap    = I2C_RDEN && !I2C_WREN && (I2C_CMD_I == ADR_EVT_L);

  // Latched faults: a new rise wins over a same-cycle clear.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      fault_lat <= '0;
    end else begin
      fault_lat <= (fault_lat & ~fault_clr) | status_rise;
    end
  end

  // RW configuration registers
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      fault_mask <= 16'hFFFF;
      ctrl       <= '0;
      scratch    <= '0;
    end else if (I2C_WREN) begin
      case (I2C_CMD_I)
        ADR_MASK_LO: fault_mask <= write_byte(fault_mask, 1'b0, I2C_DAT_I);
        ADR_MASK_HI: fault_mask <= write_byte(fault_mask, 1'b1, I2C_DAT_I);
        ADR_CTRL_LO: ctrl       <= write_byte(ctrl, 1'b0, I2C_DAT_I);
        ADR_CTRL_HI: ctrl       <= write_byte(ctrl, 1'b1, I2C_DAT_I);
        ADR_SCRATCH: scratch    <= I2C_DAT_I;
        default: ;
      endcase
    end
  end

  // Event counter: one count per clock with any unmasked rise, saturating.
  // The clear key overrides an increment in the same clock.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      evt_cnt    <= '0;
      evt_shadow <= '0;
    end else if (evt_clr) begin
      evt_cnt    <= '0;
      evt_shadow <= '0;
    end else begin
      if (evt_inc && evt_cnt != EVT_MAX) evt_cnt <= evt_cnt + 16'd1;
      // Capture the high byte when the low byte is acknowledged so a
      // following read of EVT_CNT_H is coherent with the low byte.
      if (snap) evt_shadow <= evt_cnt[15:8];
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      alert_n_q <= 1'b1;
    end else begin
      alert_n_q <= ~|(fault_lat & ~fault_mask);
    end
  end

  // Zero-latency read mux; the engine samples one clock after changing CMD.
  always_comb begin
    RD_DAT_O = RD_UNMAPPED;
    case (I2C_CMD_I)
      ADR_VERSION:   RD_DAT_O = FW_VERSION;
      ADR_BOARD_ID:  RD_DAT_O = BOARD_ID;
      ADR_STATUS_LO: RD_DAT_O = status_sync[7:0];
      ADR_STATUS_HI: RD_DAT_O = status_sync[15:8];
      ADR_FAULT_LO:  RD_DAT_O = fault_lat[7:0];
      ADR_FAULT_HI:  RD_DAT_O = fault_lat[15:8];
      ADR_MASK_LO:   RD_DAT_O = fault_mask[7:0];
      ADR_MASK_HI:   RD_DAT_O = fault_mask[15:8];
      ADR_CTRL_LO:   RD_DAT_O = ctrl[7:0];
      ADR_CTRL_HI:   RD_DAT_O = ctrl[15:8];
      ADR_SCRATCH:   RD_DAT_O = scratch;
      ADR_EVT_L:     RD_DAT_O = evt_cnt[7:0];
      ADR_EVT_H:     RD_DAT_O = evt_shadow;
      ADR_EVT_CLR:   RD_DAT_O = 8'h00;
      default:       RD_DAT_O = RD_UNMAPPED;
    endcase
  end

  assign CTRL_O  = ctrl;
  assign ALERT_N = alert_n_q;

endmodule

// File: tb/tb_smbus_register_bank.sv
// Self-checking bench for smbus_register_bank. A behavioural model tracks
// faults, mask and event count from the driven status transitions.
module tb_smbus_register_bank;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd = 8'h00;
  logic [7:0]  dat = 8'h00;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [7:0]  rd_dat;
  logic [15:0] status = 16'h0000;
  logic [15:0] ctrl;
  logic        alert_n;

  always #5 clk = ~clk;

  smbus_register_bank #(
    .FW_VERSION  (8'h01),
    .BOARD_ID    (8'h6E),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK_IN    (clk),
    .RESET_N   (rst_n),
    .I2C_CMD_I (cmd),
    .I2C_DAT_I (dat),
    .I2C_WREN  (wren),
    .I2C_RDEN  (rden),
    .RD_DAT_O  (rd_dat),
    .STATUS_I  (status),
    .CTRL_O    (ctrl),
    .ALERT_N   (alert_n)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [15:0] m_status = 16'h0000;
  logic [15:0] m_lat    = 16'h0000;
  logic [15:0] m_mask   = 16'hFFFF;
  logic [15:0] m_evt    = 16'h0000;
  logic [7:0]  m_shadow = 8'h00;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_alert_n();
    return ~|(m_lat & ~m_mask);
  endfunction

  function automatic void apply_status(input logic [15:0] v);
    logic [15:0] r;
    r = v & ~m_status;
    m_lat = m_lat | r;
    if ((|(r & ~m_mask)) && m_evt != 16'hFFFF) m_evt = m_evt + 16'd1;
    m_status = v;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd = a; dat = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    case (a)
      8'h04: m_lat  = m_lat & ~{8'h00, d};
      8'h05: m_lat  = m_lat & ~{d, 8'h00};
      8'h06: m_mask = {m_mask[15:8], d};
      8'h07: m_mask = {d, m_mask[7:0]};
      8'h0E: if (d == 8'hA5) begin m_evt = 16'h0000; m_shadow = 8'h00; end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    cmd = a;
    #1 v = rd_dat;
  endtask

  task automatic rd_snap(output logic [7:0] v);
    @(negedge clk);
    cmd = 8'h0C; rden = 1'b1;
    #1 v = rd_dat;
    @(negedge clk);
    rden = 1'b0;
    m_shadow = m_evt[15:8];
  endtask

  task automatic set_status(input logic [15:0] v);
    @(negedge clk);
    apply_status(v);
    status = v;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  // One unmasked-capable rise per clock by alternating bit 0 and bit 1.
  task automatic pump(input int n);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v = (i % 2 == 0) ? 16'h0001 : 16'h0002;
      apply_status(v);
      status = v;
    end
    set_status(16'h0000);
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] r16;
    logic        seen;

    // 1: reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("rst_ctrl", ctrl, 16'h0000);
    check("rst_alert", {15'h0, alert_n}, 16'h0001);
    rst_n = 1'b1;
    rd(8'h00, v); check("rd_version", v, 8'h01);
    rd(8'h01, v); check("rd_board_id", v, 8'h6E);
    rd(8'h06, v); check("rd_mask_lo", v, 8'hFF);
    rd(8'h07, v); check("rd_mask_hi", v, 8'hFF);
    rd(8'hFF, v); check("rd_unmapped_ff", v, 8'hFF);
    rd(8'h0C, v); check("rd_evt_rst", v, 8'h00);

    // 2: unmask bit 0, fault, alert, W1C clear
    wr(8'h06, 8'hFE);
    @(negedge clk);
    apply_status(16'h0001);
    status = 16'h0001;
    seen = 1'b0;
    for (int k = 0; k < SYNC + 2; k++) begin
      @(negedge clk);
      if (!alert_n) begin seen = 1'b1; break; end
    end
    check("alert_within_bound", {15'h0, seen}, 16'h0001);
    rd(8'h04, v); check("fault_lat_lo", v, m_lat[7:0]);
    wr(8'h04, 8'h01);
    check("alert_still_low_after_clr", {15'h0, alert_n}, 16'h0000);
    @(negedge clk);
    #1 check("alert_high_next_clk", {15'h0, alert_n}, 16'h0001);
    set_status(16'h0000);

    // 3: set wins over same-clock clear
    @(negedge clk);
    apply_status(16'h0008);
    status = 16'h0008;
    repeat (SYNC) @(negedge clk);
    cmd = 8'h04; dat = 8'h08; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    repeat (2) @(negedge clk);
    rd(8'h04, v); check("set_wins", v, 8'h08);
    check("set_wins_alert", {15'h0, alert_n}, {15'h0, m_alert_n()});
    wr(8'h04, 8'h08);
    set_status(16'h0000);
    rd(8'h04, v); check("w1c_bit3", v, m_lat[7:0]);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      r16 = 16'($urandom);
      wr(8'h06, r16[7:0]);
      wr(8'h07, r16[15:8]);
      set_status(16'($urandom));
      rd(8'h02, v); check("rnd_raw_lo", v, m_status[7:0]);
      rd(8'h03, v); check("rnd_raw_hi", v, m_status[15:8]);
      rd(8'h04, v); check("rnd_lat_lo", v, m_lat[7:0]);
      rd(8'h05, v); check("rnd_lat_hi", v, m_lat[15:8]);
      check("rnd_alert", {15'h0, alert_n}, {15'h0, m_alert_n()});
      rd_snap(v);   check("rnd_evt_lo", v, m_evt[7:0]);
      rd(8'h0D, v); check("rnd_evt_hi", v, m_shadow);
      r16 = 16'($urandom);
      wr(8'h04, r16[7:0]);
      wr(8'h05, r16[15:8]);
      @(negedge clk);
      #1 check("rnd_alert_after_clr", {15'h0, alert_n}, {15'h0, m_alert_n()});
    end
    set_status(16'h0000);

    // 4: event counter and shadow
    wr(8'h0E, 8'hA5);
    wr(8'h06, 8'h00);
    wr(8'h07, 8'h00);
    set_status(16'h0001);
    set_status(16'h0000);
    set_status(16'h0002);
    set_status(16'h0000);
    set_status(16'h000C);
    rd(8'h0C, v); check("evt_three", v, 8'h03);
    rd_snap(v);   check("evt_three_snap", v, 8'h03);
    rd(8'h0D, v); check("evt_shadow_zero", v, 8'h00);
    set_status(16'h0000);
    pump(16'h01FF - 3);
    rd_snap(v);   check("evt_1ff_lo", v, 8'hFF);
    rd(8'h0D, v); check("evt_1ff_hi", v, 8'h01);

    // 5: saturation and clear key
    pump(65400);
    rd_snap(v);   check("evt_sat_lo", v, 8'hFF);
    rd(8'h0D, v); check("evt_sat_hi", v, 8'hFF);
    set_status(16'h0100);
    rd_snap(v);   check("evt_sat_hold_lo", v, m_evt[7:0]);
    rd(8'h0D, v); check("evt_sat_hold_hi", v, m_shadow);
    wr(8'h0E, 8'h5A);
    rd(8'h0C, v); check("evt_wrong_key", v, 8'hFF);
    wr(8'h0E, 8'hA5);
    rd(8'h0C, v); check("evt_cleared_lo", v, 8'h00);
    rd(8'h0D, v); check("evt_cleared_shadow", v, 8'h00);
    rd(8'h0E, v); check("rd_evt_clr", v, 8'h00);
    rd(8'h0B, v); check("rd_unmapped_0b", v, 8'hFF);

    // 6: control, RO write ignored, async reset
    wr(8'h08, 8'h3C);
    wr(8'h09, 8'hC3);
    wr(8'h00, 8'h55);
    #1 check("ctrl_o", ctrl, 16'hC33C);
    rd(8'h00, v); check("version_ro", v, 8'h01);
    wr(8'h0A, 8'h5A);
    rd(8'h0A, v); check("scratch", v, 8'h5A);
    check("alert_before_reset", {15'h0, alert_n}, {15'h0, m_alert_n()});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_ctrl", ctrl, 16'h0000);
    check("async_rst_alert", {15'h0, alert_n}, 16'h0001);
    rd(8'h06, v); check("async_rst_mask", v, 8'hFF);
    rd(8'h0A, v); check("async_rst_scratch", v, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
